// File: rtl/conv_pipe_block.sv
// conv_pipe_block: three-stage KxK convolution of an unsigned pixel window
// against a signed fixed-point kernel held in registers.
//   S1: per-tap products, S2: lossless sum, S3: round/shift and output mapping.
// Optional build macro CONV_ROUND_EN adds a half-LSB offset before the final
// shift (round half up); without it the shift is a plain floor.
module conv_pipe_block #(
  parameter int NBIT        = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int KBIT        = 12,
  parameter int FRAC_BITS   = 10,
  parameter int OBIT        = 8,
  parameter int MODE        = 0
) (
  input  logic                                             i_clk,
  input  logic                                             i_rst_n,
  input  logic                                             i_en,
  input  logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][NBIT-1:0] i_data,
  input  logic                                             i_data_valid,
  input  logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][KBIT-1:0] i_kernel,
  input  logic                                             i_kernel_valid,
  output logic [OBIT-1:0]                                  o_pixel,
  output logic                                             o_valid,
  output logic                                             o_sat
);

  localparam int NTAP  = KERNEL_SIZE * KERNEL_SIZE;
  localparam int PW    = NBIT + KBIT + 1;
  localparam int ACC_W = PW + $clog2(NTAP);

  localparam logic signed [ACC_W-1:0] MAX_S = ACC_W'((2 ** OBIT) - 1);
  localparam logic        [ACC_W-1:0] MAX_U = ACC_W'((2 ** OBIT) - 1);

`ifdef CONV_ROUND_EN
  localparam logic signed [ACC_W-1:0] ROUND_OFS = ACC_W'(2 ** (FRAC_BITS - 1));
`else
  localparam logic signed [ACC_W-1:0] ROUND_OFS = '0;
`endif

  logic signed [KBIT-1:0]  kern_q [NTAP];
  logic signed [PW-1:0]    prod_d [NTAP];
  logic signed [PW-1:0]    prod_q [NTAP];
  logic                    s1_valid;
  logic                    s2_valid;
  logic signed [ACC_W-1:0] sum_d;
  logic signed [ACC_W-1:0] sum_q;
  logic signed [ACC_W-1:0] shifted;
  logic        [ACC_W-1:0] mag;
  logic        [OBIT-1:0]  pix_d;
  logic                    sat_d;

  // Active kernel: loads on any strobe, regardless of the pipeline enable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NTAP; i++) kern_q[i] <= '0;
    end else if (i_kernel_valid) begin
      for (int r = 0; r < KERNEL_SIZE; r++)
        for (int c = 0; c < KERNEL_SIZE; c++)
          kern_q[r*KERNEL_SIZE+c] <= $signed(i_kernel[r][c]);
    end
  end

  // Per-tap products; pixels are zero-extended so they stay non-negative.
  always_comb begin
    for (int r = 0; r < KERNEL_SIZE; r++)
      for (int c = 0; c < KERNEL_SIZE; c++)
        prod_d[r*KERNEL_SIZE+c] = PW'($signed({1'b0, i_data[r][c]}))
                                * PW'(kern_q[r*KERNEL_SIZE+c]);
  end

  // Sum of all products, wide enough that no tap combination can overflow.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NTAP; i++) sum_d = sum_d + ACC_W'(prod_q[i]);
  end

  // Final scaling and mapping to the unsigned output range.
  always_comb begin
    shifted = (sum_q + ROUND_OFS) >>> FRAC_BITS;
    mag     = '0;
    pix_d   = '0;
    sat_d   = 1'b0;
    if (MODE == 0) begin
      if (shifted < 0) begin
        pix_d = '0;
        sat_d = 1'b1;
      end else if (shifted > MAX_S) begin
        pix_d = '1;
        sat_d = 1'b1;
      end else begin
        pix_d = shifted[OBIT-1:0];
      end
    end else begin
      mag = shifted[ACC_W-1] ? -shifted : shifted;
      if (mag > MAX_U) begin
        pix_d = '1;
        sat_d = 1'b1;
      end else begin
        pix_d = mag[OBIT-1:0];
      end
    end
  end

  // Stage valids and outputs; empty slots leave the outputs untouched.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      o_valid  <= 1'b0;
      o_pixel  <= '0;
      o_sat    <= 1'b0;
    end else if (i_en) begin
      s1_valid <= i_data_valid;
      s2_valid <= s1_valid;
      o_valid  <= s2_valid;
      if (s2_valid) begin
        o_pixel <= pix_d;
        o_sat   <= sat_d;
      end
    end
  end

  // Datapath registers carry no reset; their contents only matter behind a valid.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_data_valid) prod_q <= prod_d;
      if (s1_valid) sum_q <= sum_d;
    end
  end

endmodule

// File: tb/tb_conv_pipe_block.sv
// Testbench for conv_pipe_block: one instance per output mapping mode, fed the
// same stimulus, checked by a queue-based scoreboard against an integer model.
module tb_conv_pipe_block;

  localparam int NBIT = 8;
  localparam int KS   = 3;
  localparam int KBIT = 12;
  localparam int FRAC = 10;
  localparam int OBIT = 8;
  localparam int OMAX = (1 << OBIT) - 1;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b1;
  logic i_en = 1'b0;
  logic i_data_valid = 1'b0;
  logic i_kernel_valid = 1'b0;
  logic [KS-1:0][KS-1:0][NBIT-1:0] i_data = '0;
  logic [KS-1:0][KS-1:0][KBIT-1:0] i_kernel = '0;
  logic [OBIT-1:0] pix0, pix1;
  logic val0, val1, sat0, sat1;

  conv_pipe_block #(.NBIT(NBIT), .KERNEL_SIZE(KS), .KBIT(KBIT), .FRAC_BITS(FRAC),
                    .OBIT(OBIT), .MODE(0)) u_dut0 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_data(i_data),
    .i_data_valid(i_data_valid), .i_kernel(i_kernel), .i_kernel_valid(i_kernel_valid),
    .o_pixel(pix0), .o_valid(val0), .o_sat(sat0));

  conv_pipe_block #(.NBIT(NBIT), .KERNEL_SIZE(KS), .KBIT(KBIT), .FRAC_BITS(FRAC),
                    .OBIT(OBIT), .MODE(1)) u_dut1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_data(i_data),
    .i_data_valid(i_data_valid), .i_kernel(i_kernel), .i_kernel_valid(i_kernel_valid),
    .o_pixel(pix1), .o_valid(val1), .o_sat(sat1));

  always #5 i_clk = ~i_clk;

  typedef struct {
    int pix;
    bit sat;
    int stamp;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   en_cnt = 0;
  bit   en_last = 1'b0;
  bit   drain_check = 1'b0;
  int   win[KS][KS];
  int   nk[KS][KS];
  int   mk[KS][KS];
  logic [OBIT-1:0] pp[2];
  logic            pv[2];
  logic            ps[2];

  // Count enabled edges so latency can be measured in enabled cycles.
  always @(posedge i_clk) begin
    en_last <= i_en;
    if (i_en) en_cnt <= en_cnt + 1;
  end

  // Reference: integer dot product, optional half-LSB round, floor shift, map.
  task automatic push_expect();
    int s, v, m;
    exp_t e0, e1;
    s = 0;
    for (int r = 0; r < KS; r++)
      for (int c = 0; c < KS; c++)
        s += win[r][c] * mk[r][c];
`ifdef CONV_ROUND_EN
    s += 1 << (FRAC - 1);
`endif
    v = s >>> FRAC;
    if (v < 0) begin e0.pix = 0; e0.sat = 1'b1; end
    else if (v > OMAX) begin e0.pix = OMAX; e0.sat = 1'b1; end
    else begin e0.pix = v; e0.sat = 1'b0; end
    m = (v < 0) ? -v : v;
    if (m > OMAX) begin e1.pix = OMAX; e1.sat = 1'b1; end
    else begin e1.pix = m; e1.sat = 1'b0; end
    e0.stamp = en_cnt;
    e1.stamp = en_cnt;
    q0.push_back(e0);
    q1.push_back(e1);
  endtask

  // Present one cycle of inputs and update the model as the DUT should.
  task automatic cyc(input bit en, input bit dv, input bit kv);
    i_en = en;
    i_data_valid = dv;
    i_kernel_valid = kv;
    for (int r = 0; r < KS; r++)
      for (int c = 0; c < KS; c++) begin
        i_data[r][c]   = NBIT'(win[r][c]);
        i_kernel[r][c] = KBIT'(nk[r][c]);
      end
    if (i_rst_n && en && dv) push_expect();
    if (i_rst_n && kv) mk = nk;
    @(posedge i_clk);
    #1;
  endtask

  task automatic fill_win(input int v);
    for (int r = 0; r < KS; r++)
      for (int c = 0; c < KS; c++) win[r][c] = v;
  endtask

  task automatic fill_k(input int v);
    for (int r = 0; r < KS; r++)
      for (int c = 0; c < KS; c++) nk[r][c] = v;
  endtask

  task automatic check_inst(input int inst, input logic v, input logic [OBIT-1:0] p,
                            input logic s);
    exp_t e;
    if (!v) return;
    n_tests++;
    if ((inst == 0 && q0.size() == 0) || (inst == 1 && q1.size() == 0)) begin
      n_fail++;
      $display("FAIL unexpected_valid mode%0d: got pixel=%0d sat=%0d, required no output",
               inst, p, s);
      return;
    end
    e = (inst == 0) ? q0.pop_front() : q1.pop_front();
    if (p != OBIT'(e.pix) || s != e.sat) begin
      n_fail++;
      $display("FAIL result mode%0d: got pixel=%0d sat=%0d, required pixel=%0d sat=%0d",
               inst, p, s, e.pix, e.sat);
    end
    n_tests++;
    if (en_cnt - e.stamp != 3) begin
      n_fail++;
      $display("FAIL latency mode%0d: got %0d enabled cycles, required 3",
               inst, en_cnt - e.stamp);
    end
  endtask

  // Monitor: reset clearing, scoreboard pops on fresh outputs, hold during stalls.
  always begin
    @(negedge i_clk or negedge i_rst_n);
    if (!i_rst_n) begin
      #1;
      q0.delete();
      q1.delete();
      n_tests++;
      if (val0 || pix0 != 0 || sat0 || val1 || pix1 != 0 || sat1) begin
        n_fail++;
        $display("FAIL reset_clear: got v=%0d/%0d pix=%0d/%0d sat=%0d/%0d, required all 0",
                 val0, val1, pix0, pix1, sat0, sat1);
      end
    end else if (en_last) begin
      check_inst(0, val0, pix0, sat0);
      check_inst(1, val1, pix1, sat1);
    end else begin
      n_tests++;
      if (val0 != pv[0] || pix0 != pp[0] || sat0 != ps[0] ||
          val1 != pv[1] || pix1 != pp[1] || sat1 != ps[1]) begin
        n_fail++;
        $display("FAIL stall_hold: got v=%0d/%0d pix=%0d/%0d sat=%0d/%0d, required v=%0d/%0d pix=%0d/%0d sat=%0d/%0d",
                 val0, val1, pix0, pix1, sat0, sat1,
                 pv[0], pv[1], pp[0], pp[1], ps[0], ps[1]);
      end
    end
    if (drain_check) begin
      n_tests++;
      if (q0.size() != 0 || q1.size() != 0) begin
        n_fail++;
        $display("FAIL drain: got %0d/%0d outputs still owed, required 0/0",
                 q0.size(), q1.size());
      end
    end
    pv[0] = val0; pp[0] = pix0; ps[0] = sat0;
    pv[1] = val1; pp[1] = pix1; ps[1] = sat1;
  end

  initial begin
    fill_win(0);
    fill_k(0);
    mk = nk;
    #2 i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;

    // Gaussian, flat 100 window -> 100
    nk = '{'{64, 128, 64}, '{128, 256, 128}, '{64, 128, 64}};
    cyc(1, 0, 1);
    fill_win(100);
    cyc(1, 1, 0);
    repeat (3) cyc(1, 0, 0);

    // All 1024, all 255 -> saturates high
    fill_k(1024);
    cyc(1, 0, 1);
    fill_win(255);
    cyc(1, 1, 0);
    repeat (3) cyc(1, 0, 0);

    // Sobel with bright left column -> -200
    nk = '{'{-1024, 0, 1024}, '{-2048, 0, 2048}, '{-1024, 0, 1024}};
    cyc(1, 0, 1);
    win = '{'{50, 0, 0}, '{50, 0, 0}, '{50, 0, 0}};
    cyc(1, 1, 0);
    repeat (3) cyc(1, 0, 0);

    // Center-only 512 on pixel 3 -> 1.5 before rounding
    fill_k(0);
    nk[1][1] = 512;
    cyc(1, 0, 1);
    for (int r = 0; r < KS; r++)
      for (int c = 0; c < KS; c++) win[r][c] = $urandom_range(0, 255);
    win[1][1] = 3;
    cyc(1, 1, 0);
    repeat (3) cyc(1, 0, 0);

    // Kernel load coincident with window A, B next, then a 2-cycle stall
    fill_win(10);
    fill_k(1024);
    cyc(1, 1, 1);
    cyc(1, 1, 0);
    fill_win(77);
    cyc(0, 1, 0);
    cyc(0, 1, 1);
    repeat (4) cyc(1, 0, 0);

    // Randomized traffic with stalls and kernel reloads
    repeat (300) begin
      for (int r = 0; r < KS; r++)
        for (int c = 0; c < KS; c++) begin
          win[r][c] = ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 255);
          nk[r][c]  = $urandom_range(0, 4095) - 2048;
        end
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
          $urandom_range(0, 9) == 0);
    end

    // Reset with two windows in flight; kernel strobes during reset are ignored
    fill_win(7);
    cyc(1, 1, 0);
    cyc(1, 1, 0);
    #2 i_rst_n = 1'b0;
    fill_k(0);
    mk = nk;
    fill_k(1000);
    cyc(1, 1, 1);
    cyc(1, 1, 1);
    i_rst_n = 1'b1;
    fill_win(200);
    cyc(1, 1, 0);
    nk = '{'{64, 128, 64}, '{128, 256, 128}, '{64, 128, 64}};
    cyc(1, 0, 1);
    cyc(1, 1, 0);
    repeat (6) cyc(1, 0, 0);

    drain_check = 1'b1;
    @(negedge i_clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_pipe_block.md
CONV_PIPE_BLOCK -- requirements
Module: conv_pipe_block

Interface
REQ-001 SHALL provide parameter NBIT, default 8: unsigned pixel width.
REQ-002 SHALL provide parameter KERNEL_SIZE, default 3: square window side.
REQ-003 SHALL provide parameter KBIT, default 12: signed two's-complement coefficient width.
REQ-004 SHALL provide parameter FRAC_BITS, default 10: fractional bits of coefficients.
REQ-005 SHALL provide parameter OBIT, default 8: unsigned output pixel width.
REQ-006 SHALL provide parameter MODE, default 0: output mapping, 0 = clamp negatives to 0, 1 = absolute value.
REQ-007 SHALL provide port i_clk  in  1  sole clock, rising edge.
REQ-008 SHALL provide port i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-009 SHALL provide port i_en  in  1  pipeline advance enable; low stalls every stage.
REQ-010 SHALL provide port i_data  in  [KERNEL_SIZE][KERNEL_SIZE] x NBIT  pixel window.
REQ-011 SHALL provide port i_data_valid  in  1  window valid.
REQ-012 SHALL provide port i_kernel  in  [KERNEL_SIZE][KERNEL_SIZE] x KBIT  signed coefficients.
REQ-013 SHALL provide port i_kernel_valid  in  1  coefficient load strobe.
REQ-014 SHALL provide port o_pixel  out  OBIT  result pixel.
REQ-015 SHALL provide port o_valid  out  1  o_pixel valid.
REQ-016 SHALL provide port o_sat  out  1  result was clamped or saturated.

Function
REQ-017 SHALL implement three registered stages, all advancing only when i_en=1: S1 products, S2 sum, S3 round/shift/map.
REQ-018 SHALL produce o_valid/o_pixel exactly 3 enabled cycles after the cycle in which i_data_valid=1 and i_en=1.
REQ-019 SHALL carry a valid bit per stage; invalid slots SHALL NOT raise o_valid, and SHALL leave o_pixel/o_sat holding their last values.
REQ-020 SHALL compute each product as zero-extended pixel (NBIT+1 signed) times coefficient, giving NBIT+KBIT+1 bits.
REQ-021 SHALL sum all products losslessly in ACC_W = NBIT+KBIT+1+$clog2(KERNEL_SIZE*KERNEL_SIZE) signed bits.
REQ-022 SHALL shift the sum arithmetically right by FRAC_BITS (floor), after the optional rounding offset (REQ-031).
REQ-023 SHALL, when MODE=0, output 0 with o_sat=1 for negative results, 2^OBIT-1 with o_sat=1 for results above it, else the value with o_sat=0.
REQ-024 SHALL, when MODE=1, take the magnitude, then saturate to 2^OBIT-1 with o_sat=1 when exceeded.
REQ-025 SHALL hold the active kernel in registers, updated on any rising edge with i_kernel_valid=1, independent of i_en.
REQ-026 SHALL use the old kernel for a window accepted in the same cycle as a kernel load, and the new kernel from the next accepted window on; windows already past S1 SHALL be unaffected.
REQ-027 SHALL, while i_en=0, hold all stage registers and outputs; inputs presented then are ignored.

Reset
REQ-028 SHALL, on i_rst_n low, asynchronously clear all stage valids, o_valid, o_sat and o_pixel to 0, and all active coefficients to 0.
REQ-029 SHALL discard in-flight windows on reset; the first o_valid after release SHALL come from a window accepted after release.
REQ-030 SHALL ignore i_kernel_valid while i_rst_n is low.

Configuration
REQ-031 SHALL, with CONV_ROUND_EN defined, add 2^(FRAC_BITS-1) to the sum before the shift (round half up); without it, truncate by floor shift only.

Verification
REQ-032 SHALL cover Gaussian kernel {64,128,64;128,256,128;64,128,64}, all pixels 100 -> o_pixel=100, o_sat=0, o_valid 3 cycles after input.
REQ-033 SHALL cover all coefficients 1024, all pixels 255 -> sum 2295 -> o_pixel=255, o_sat=1.
REQ-034 SHALL cover Sobel {-1024,0,1024;-2048,0,2048;-1024,0,1024}, left column 50, right column 0 -> MODE=0: o_pixel=0, o_sat=1; MODE=1: o_pixel=200, o_sat=0.
REQ-035 SHALL cover center-only coefficient 512, pixel 3 -> o_pixel=2 with CONV_ROUND_EN, 1 without.
REQ-036 SHALL cover a kernel load coincident with window A, window B next cycle, and i_en low 2 cycles mid-stream -> A uses the old kernel, B the new, and outputs are held and delayed 2 cycles.
REQ-037 SHALL cover i_rst_n pulsed low with 2 windows in flight -> outputs 0 immediately, no o_valid for those windows.
